// File: rtl/ad9866_spi_responder.sv
// AD9866 serial control port responder: 16-bit frames, MSB first, 4-wire mode.
// Holds the control register file, commits writes, returns register data on sdo
// and exposes the RX/TX gain fields.
module ad9866_spi_responder #(
  parameter int unsigned NUM_REGS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       sen_n,
  input  logic       sdio,
  output logic       sdo,
  output logic       wr_stb,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [5:0] rx_gain,
  output logic [5:0] tx_gain,
  output logic       frame_err
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StInstr = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [4:0] bitcnt_q, bitcnt_d;
  logic [6:0] shreg_q, shreg_d;
  logic [4:0] addr_q, addr_d;
  logic       rd_q, rd_d;
  logic       sdo_q, sdo_d;
  logic       armed_q, armed_d;
  logic       sclk_q;
  logic       wr_stb_q, wr_stb_d;
  logic [4:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       frame_err_q, frame_err_d;
  logic       commit;
  logic [7:0] regs_q [NUM_REGS];

  logic       rise, fall;
  logic [7:0] shift_val;
  logic [7:0] rdbuf;
  logic       addr_ok;

  assign rise      = sclk & ~sclk_q & ~sen_n;
  assign fall      = ~sclk & sclk_q & ~sen_n;
  assign shift_val = {shreg_q, sdio};
  assign addr_ok   = 32'(addr_q) < NUM_REGS;

  // Read buffer and gain taps decoded from the register file.
  always_comb begin
    rdbuf   = 8'h00;
    rx_gain = 6'd0;
    tx_gain = 6'd0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (addr_q == i[4:0]) rdbuf = regs_q[i];
      if (i == 9)  rx_gain = regs_q[i][5:0];
      if (i == 10) tx_gain = regs_q[i][5:0];
    end
  end

  // Frame sequencing, shifting, commit decision and sdo next-state.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    sdo_d       = sdo_q;
    armed_d     = armed_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    commit      = 1'b0;

    if (sen_n) begin
      // Deselect mid-frame is an abort.
      if (bitcnt_q != 5'd0 && bitcnt_q != 5'd16) frame_err_d = 1'b1;
      state_d  = StIdle;
      bitcnt_d = 5'd0;
      sdo_d    = 1'b0;
      armed_d  = 1'b1;
    end else if (armed_q) begin
      // armed_q blocks frames that were already in progress when reset hit.
      case (state_q)
        StIdle, StInstr: begin
          state_d = StInstr;
          if (rise) begin
            shreg_d  = shift_val[6:0];
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              addr_d  = shift_val[4:0];
              rd_d    = shift_val[7];
              state_d = StData;
            end
          end
        end
        StData: begin
          if (rise) begin
            shreg_d  = shift_val[6:0];
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd15) begin
              state_d = StDone;
              if (!rd_q) begin
                if (addr_ok) begin
                  commit    = 1'b1;
                  wr_stb_d  = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = shift_val;
                end else begin
                  frame_err_d = 1'b1;
                end
              end
            end
          end
        end
        default: ;  // StDone: rises ignored, bitcnt stays at 16
      endcase

      // bitcnt 8..15 maps to rdbuf bit 7..0, i.e. the inverted low three bits.
      if (fall) begin
        if (rd_q && bitcnt_q >= 5'd8 && bitcnt_q < 5'd16) sdo_d = rdbuf[~bitcnt_q[2:0]];
        else sdo_d = 1'b0;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      bitcnt_q    <= 5'd0;
      shreg_q     <= 7'd0;
      addr_q      <= 5'd0;
      rd_q        <= 1'b0;
      sdo_q       <= 1'b0;
      armed_q     <= 1'b0;
      sclk_q      <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 8'd0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      sdo_q       <= sdo_d;
      armed_q     <= armed_d;
      sclk_q      <= sclk;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Register file; writes land on the edge after the 16th rise.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (reset) regs_q[i] <= 8'h00;
      else if (commit && addr_q == i[4:0]) regs_q[i] <= shift_val;
    end
  end

  assign sdo       = sdo_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Self-checking bench for ad9866_spi_responder: bit-banged SPI master, register
// model, and scoreboard queues for committed writes and read data.
module tb_ad9866_spi_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       sen_n = 1'b1;
  logic       sdio = 1'b0;
  logic       sdo;
  logic       wr_stb;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] rx_gain;
  logic [5:0] tx_gain;
  logic       frame_err;

  ad9866_spi_responder #(.NUM_REGS(20)) dut (
    .clk      (clk),
    .reset    (reset),
    .sclk     (sclk),
    .sen_n    (sen_n),
    .sdio     (sdio),
    .sdo      (sdo),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rx_gain  (rx_gain),
    .tx_gain  (tx_gain),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int stb_cnt = 0;
  int ferr_cnt = 0;
  logic [12:0] wr_exp_q[$];
  logic [7:0]  rd_exp_q[$];
  logic [7:0]  model [32];

  // Write scoreboard: every wr_stb must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) ferr_cnt++;
      if (wr_stb) begin
        logic [12:0] e;
        stb_cnt++;
        checks++;
        if (wr_exp_q.size() == 0) begin
          $display("FAIL wr_unexpected: got addr=%h data=%h, expected no write", wr_addr, wr_data);
        end else begin
          e = wr_exp_q.pop_front();
          if ({wr_addr, wr_data} !== e)
            $display("FAIL wr_commit: got addr=%h data=%h, expected addr=%h data=%h",
                     wr_addr, wr_data, e[12:8], e[7:0]);
          else passes++;
        end
      end
    end
  end

  // Bit-banged master: 2 clk low, 2 clk high per bit; samples sdo in the high phase.
  task automatic spi_frame(input logic [15:0] tx, input int nrise, input bit fast,
                           input bit hold, output logic [15:0] rx);
    rx = 16'h0000;
    for (int b = 0; b < nrise; b++) begin
      @(negedge clk);
      if (fast && b == 0) begin
        sen_n = 1'b0;
        sdio  = tx[15];
      end else begin
        sen_n = 1'b0;
        sclk  = 1'b0;
        sdio  = tx[15-b];
        @(negedge clk);
        @(negedge clk);
      end
      sclk = 1'b1;
      @(negedge clk);
      rx[15-b] = sdo;
    end
    @(negedge clk);
    sclk = 1'b0;
    @(negedge clk);
    if (!hold) sen_n = 1'b1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d, input bit fast);
    logic [15:0] rx;
    if (a < 5'd20) begin
      wr_exp_q.push_back({a, d});
      model[a] = d;
    end
    spi_frame({3'b000, a, d}, 16, fast, 1'b0, rx);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [4:0] a, output logic [15:0] rx);
    rd_exp_q.push_back((a < 5'd20) ? model[a] : 8'h00);
    spi_frame({3'b100, a, 8'h00}, 16, 1'b0, 1'b0, rx);
    @(negedge clk);
  endtask

  task automatic check_read(input string name, input logic [15:0] rx);
    logic [7:0] e;
    e = rd_exp_q.pop_front();
    checks++;
    if (rx[7:0] !== e) $display("FAIL %s_data: got %h expected %h", name, rx[7:0], e);
    else passes++;
    checks++;
    if (rx[15:8] !== 8'h00) $display("FAIL %s_hi: got %h expected 00", name, rx[15:8]);
    else passes++;
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({sdo, wr_stb, wr_addr, wr_data, rx_gain, tx_gain, frame_err} !== 29'd0)
      $display("FAIL %s: got sdo=%b stb=%b addr=%h data=%h rx=%h tx=%h err=%b, expected all 0",
               name, sdo, wr_stb, wr_addr, wr_data, rx_gain, tx_gain, frame_err);
    else passes++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int s0 = stb_cnt;
    do_write(5'h09, 8'h55, 1'b0);
    checks++;
    if (stb_cnt - s0 !== 1) $display("FAIL write_stb_count: got %0d expected 1", stb_cnt - s0);
    else passes++;
    checks++;
    if (wr_addr !== 5'h09 || wr_data !== 8'h55)
      $display("FAIL write_last: got %h/%h expected 09/55", wr_addr, wr_data);
    else passes++;
    checks++;
    if (rx_gain !== 6'h15 || tx_gain !== 6'h00)
      $display("FAIL write_gain: got rx=%h tx=%h expected rx=15 tx=00", rx_gain, tx_gain);
    else passes++;
  endtask

  task automatic test_readback();
    logic [15:0] rx;
    int s0;
    do_write(5'h04, 8'h36, 1'b0);
    s0 = stb_cnt;
    do_read(5'h04, rx);
    check_read("readback", rx);
    checks++;
    if (stb_cnt !== s0) $display("FAIL readback_no_stb: got %0d strobes expected 0", stb_cnt - s0);
    else passes++;
  endtask

  task automatic test_abort();
    logic [15:0] rx;
    int f0 = ferr_cnt;
    int s0 = stb_cnt;
    spi_frame(16'h0A3F, 10, 1'b0, 1'b0, rx);
    repeat (3) @(negedge clk);
    checks++;
    if (ferr_cnt - f0 !== 1) $display("FAIL abort_err: got %0d pulses expected 1", ferr_cnt - f0);
    else passes++;
    checks++;
    if (tx_gain !== 6'h00 || stb_cnt !== s0)
      $display("FAIL abort_nowrite: got tx=%h stb=%0d expected tx=00 stb=0", tx_gain, stb_cnt - s0);
    else passes++;
    do_write(5'h0A, 8'h3F, 1'b0);
    checks++;
    if (tx_gain !== 6'h3F) $display("FAIL abort_recover: got tx=%h expected 3f", tx_gain);
    else passes++;
  endtask

  task automatic test_out_of_range();
    logic [15:0] rx;
    int f0 = ferr_cnt;
    int s0 = stb_cnt;
    do_write(5'h1F, 8'hAA, 1'b0);
    checks++;
    if (ferr_cnt - f0 !== 1 || stb_cnt !== s0)
      $display("FAIL oor_write: got err=%0d stb=%0d expected err=1 stb=0",
               ferr_cnt - f0, stb_cnt - s0);
    else passes++;
    do_read(5'h1F, rx);
    check_read("oor_read", rx);
  endtask

  // One clk of sen_n high between frames; second frame starts with sen_n fall plus sclk rise.
  task automatic test_back_to_back();
    logic [15:0] rx;
    int s0 = stb_cnt;
    wr_exp_q.push_back({5'h0B, 8'hC3});
    model[5'h0B] = 8'hC3;
    spi_frame(16'h0BC3, 16, 1'b0, 1'b0, rx);
    wr_exp_q.push_back({5'h0C, 8'h5A});
    model[5'h0C] = 8'h5A;
    spi_frame(16'h0C5A, 16, 1'b1, 1'b0, rx);
    repeat (2) @(negedge clk);
    checks++;
    if (stb_cnt - s0 !== 2) $display("FAIL b2b_count: got %0d expected 2", stb_cnt - s0);
    else passes++;
    do_read(5'h0B, rx);
    check_read("b2b_rd0b", rx);
  endtask

  task automatic test_init_sequence();
    logic [4:0]  addrs [11];
    logic [7:0]  datas [11];
    logic [15:0] rx;
    int s0 = stb_cnt;
    addrs = '{5'h00, 5'h04, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h11};
    datas = '{8'h80, 8'h36, 8'h01, 8'hA5, 8'h5A, 8'h2C, 8'h13, 8'hFF, 8'h00, 8'h7E, 8'h81};
    for (int i = 0; i < 11; i++) do_write(addrs[i], datas[i], 1'b0);
    checks++;
    if (stb_cnt - s0 !== 11) $display("FAIL init_stb_count: got %0d expected 11", stb_cnt - s0);
    else passes++;
    checks++;
    if (rx_gain !== 6'h2C || tx_gain !== 6'h13)
      $display("FAIL init_gain: got rx=%h tx=%h expected 2c/13", rx_gain, tx_gain);
    else passes++;
    for (int i = 0; i < 11; i++) begin
      do_read(addrs[i], rx);
      check_read("init_rd", rx);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] rx;
    int s0, f0;
    spi_frame(16'h0977, 12, 1'b0, 1'b1, rx);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    check_outputs_zero("midreset_outputs");
    // Remaining rises of the lost frame must be ignored, with no error on deselect.
    s0 = stb_cnt;
    f0 = ferr_cnt;
    spi_frame(16'h0977, 4, 1'b0, 1'b0, rx);
    repeat (3) @(negedge clk);
    checks++;
    if (stb_cnt !== s0 || ferr_cnt !== f0)
      $display("FAIL midreset_ignore: got stb=%0d err=%0d expected 0/0",
               stb_cnt - s0, ferr_cnt - f0);
    else passes++;
    do_write(5'h09, 8'h01, 1'b0);
    checks++;
    if (rx_gain !== 6'h01) $display("FAIL midreset_recover: got rx=%h expected 01", rx_gain);
    else passes++;
    do_read(5'h04, rx);
    check_read("midreset_reg04", rx);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    test_reset();
    test_write();
    test_readback();
    test_abort();
    test_out_of_range();
    test_back_to_back();
    test_init_sequence();
    test_reset_midframe();
    repeat (4) @(negedge clk);
    checks++;
    if (wr_exp_q.size() != 0)
      $display("FAIL wr_missing: got %0d uncommitted writes expected 0", wr_exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ad9866_spi_responder.md
# ad9866_spi_responder

Clock-synchronous SPI responder modelling the AD9866 serial control port as seen from the FPGA-side SPI master: 16-bit frames, MSB first, 4-wire mode. It holds the 20-register AD9866 control file, applies writes, and returns register contents on `sdo` for reads. Used as a bench/loopback target for the configuration master and as a register shadow exposing RX/TX gain fields to the rest of the design.

## Interface
- `NUM_REGS`, 20: implemented addresses are 0x00..NUM_REGS-1; range 1..32.
- `clk`  in  1  system clock; the same clock that drives the SPI master.
- `reset`  in  1  synchronous, active-high reset.
- `sclk`  in  1  SPI clock from master; idle low; each phase lasts at least one `clk`.
- `sen_n`  in  1  active-low frame enable.
- `sdio`  in  1  serial data from master, MSB first.
- `sdo`  out  1  serial read data to master.
- `wr_stb`  out  1  one-cycle pulse per committed register write.
- `wr_addr`  out  5  address of the last committed write.
- `wr_data`  out  8  data of the last committed write.
- `rx_gain`  out  6  register 0x09[5:0].
- `tx_gain`  out  6  register 0x0A[5:0].
- `frame_err`  out  1  one-cycle pulse on an aborted or out-of-range frame.

## Operation
- Frame: instruction byte {R/W, N1, N0, A4..A0}, then data byte D7..D0. R/W=1 is a read. N1/N0 are ignored; every frame is single-byte.
- Edge detect: `sclk_q` is `sclk` registered.
  - rise = `sclk` & !`sclk_q`.
  - fall = !`sclk` & `sclk_q`.
  - Both are qualified by `sen_n`=0.
- States:
  - IDLE: `sen_n`=1. `bitcnt`=0, `sdo`=0.
  - IDLE→INSTR: on `sen_n`=0.
  - INSTR: each rise shifts `sdio` into `shreg` and increments `bitcnt`. At `bitcnt`=8, latch `addr`=`shreg`[4:0] and `rd`=`shreg`[7]; go to DATA.
  - DATA: each rise shifts `sdio` and increments `bitcnt`. On the 16th rise go to DONE.
    - Write frame with `addr`<NUM_REGS: commit `reg[addr]`=`shreg`[7:0] (the 8 data bits).
    - Write frame with `addr`≥NUM_REGS: drop the write and pulse `frame_err`.
  - DONE: further rises are ignored and `bitcnt` saturates at 16.
  - Any state: `sen_n`=1 returns to IDLE on the next edge.
- Read path:
  - On each fall with 8≤`bitcnt`<16, `sdo` ← `rdbuf`[15-`bitcnt`].
  - `rdbuf` is `reg[addr]`, or 0x00 if `addr`≥NUM_REGS. It is loaded combinationally from the latched address.
  - `sdo` is 0 at all other times, including for write frames.
- Abort: `sen_n` rising while 0<`bitcnt`<16 discards the frame. No write, `frame_err` pulses once.
- Register reset values: all 0x00.
- Register 0x00 bit 7 (4-wire enable) is stored but does not change behaviour; `sdo` is always driven.

## Timing
- Reset: all state is cleared on the `clk` edge where `reset`=1, including a reset mid-frame.
  - `sdo`=0, `wr_stb`=0, `wr_addr`=0, `wr_data`=0, `rx_gain`=0, `tx_gain`=0, `frame_err`=0.
  - All registers are 0x00, state is IDLE.
  - A frame in progress when reset hits is lost. The responder waits for `sen_n`=1 before accepting a new frame.
- Write latency: the register, `wr_addr`/`wr_data`, `wr_stb`, and the gain outputs all update on the `clk` edge that ends the cycle in which the 16th rise is detected. `wr_stb` is high for exactly that one following cycle.
- Read timing:
  - `sdo` bit k changes at the edge ending each fall cycle.
  - It is stable for the entire next `sclk`-high phase, when the master samples it.
  - Minimum `sclk` timing is 1 `clk` high, 1 `clk` low.
- `frame_err` pulses one cycle after the offending `sen_n` rise, or in the same cycle as the would-be commit for an out-of-range write.
- Back-to-back frames: one `clk` of `sen_n`=1 between frames is sufficient.
- `sen_n` falling and `sclk` rising in the same cycle: the rise counts as bit 15 (MSB).

## Test plan
- Write: frame 0x0955 → `wr_stb` pulses once, `wr_addr`=0x09, `wr_data`=0x55, `rx_gain`=0x15, `tx_gain` stays 0x00.
- Read-back: write 0x0436, then frame 0x8400 → the master's captured low byte is 0x36, high byte is 0x00, and `wr_stb` does not pulse during the read.
- Full master init sequence (writes to 0x00, 0x04, 0x06–0x0D, 0x11) then read each back → every readback matches, and `wr_stb` count equals 11.
- Abort: raise `sen_n` after 10 rises of frame 0x0A3F → no register change, `tx_gain`=0x00, `frame_err` pulses once; a following valid frame 0x0A3F gives `tx_gain`=0x3F.
- Out of range: write frame 0x1FAA → no `wr_stb`, `frame_err` pulses once; read 0x9F00 → data 0x00.
- Reset mid-frame: assert `reset` after 12 rises of 0x0977 → all outputs 0; the next frame 0x0901 after `sen_n` toggles gives `rx_gain`=0x01.
